// File: rtl/alarm_scheduler.sv
// Multi-slot alarm controller: stores SLOTS alarm times, matches them against the
// running time on each second tick, and sequences ring / snooze / dismiss.
module alarm_scheduler #(
    parameter int SLOTS       = 4,
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    localparam int SW         = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sec_tick,
    input  logic [7:0]    cur_hour,
    input  logic [7:0]    cur_min,
    input  logic [7:0]    cur_sec,
    input  logic          cfg_we,
    input  logic [SW-1:0] cfg_slot,
    input  logic [7:0]    cfg_hour,
    input  logic [7:0]    cfg_min,
    input  logic [7:0]    cfg_sec,
    input  logic          cfg_en,
    input  logic          stop,
    input  logic          snooze,
    output logic          alarm_out,
    output logic [SW-1:0] ring_slot,
    output logic          snoozing,
    output logic          cfg_err
);

    localparam int RW  = $clog2(RING_SECS + 1);
    localparam int SNW = $clog2(SNOOZE_SECS + 1);
    localparam logic [RW-1:0]  RING_LAST = RW'(RING_SECS - 1);
    localparam logic [SNW-1:0] SNZ_INIT  = SNW'(SNOOZE_SECS - 1);
    localparam logic [SW:0]    SLOTS_LIM = (SW + 1)'(SLOTS);

    typedef enum logic [1:0] {S_IDLE, S_RING, S_SNOOZE} state_t;

    typedef struct packed {
        logic [7:0] hour;
        logic [7:0] min;
        logic [7:0] sec;
        logic       en;
    } slot_t;

    slot_t          slot_q [SLOTS];
    slot_t          slot_d [SLOTS];
    state_t         state_q, state_d;
    logic [RW-1:0]  ring_cnt_q, ring_cnt_d;
    logic [SNW-1:0] snz_cnt_q, snz_cnt_d;
    logic [SW-1:0]  ring_slot_q, ring_slot_d;
    logic           alarm_out_q, alarm_out_d;
    logic           snoozing_q, snoozing_d;
    logic           cfg_err_q, cfg_err_d;

    logic          cfg_ok;
    logic          cancel;
    logic          any_match;
    logic [SW-1:0] win_idx;

    assign cfg_ok = (cfg_hour <= 8'd23) && (cfg_min <= 8'd59) && (cfg_sec <= 8'd59)
                 && ({1'b0, cfg_slot} < SLOTS_LIM);

    // A disabling write to the slot currently ringing/snoozing cancels it.
    assign cancel = cfg_we && cfg_ok && !cfg_en && (cfg_slot == ring_slot_q)
                 && (state_q != S_IDLE);

    // Scan high-to-low so the lowest matching index is the last one assigned.
    always_comb begin
        any_match = 1'b0;
        win_idx   = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (slot_q[i].en && slot_q[i].hour == cur_hour &&
                slot_q[i].min == cur_min && slot_q[i].sec == cur_sec) begin
                any_match = 1'b1;
                win_idx   = SW'(i);
            end
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        for (int i = 0; i < SLOTS; i++) slot_d[i] = slot_q[i];
        cfg_err_d = 1'b0;
        if (cfg_we) begin
            if (cfg_ok) slot_d[cfg_slot] = '{hour: cfg_hour, min: cfg_min, sec: cfg_sec, en: cfg_en};
            else        cfg_err_d = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        ring_cnt_d  = ring_cnt_q;
        snz_cnt_d   = snz_cnt_q;
        ring_slot_d = ring_slot_q;
        unique case (state_q)
            S_IDLE: begin
                if (sec_tick && any_match) begin
                    state_d     = S_RING;
                    ring_slot_d = win_idx;
                    ring_cnt_d  = '0;
                end
            end
            S_RING: begin
                if (stop || cancel) begin
                    state_d = S_IDLE;
                end else if (snooze) begin
                    state_d   = S_SNOOZE;
                    snz_cnt_d = SNZ_INIT;
                end else if (sec_tick) begin
                    if (ring_cnt_q == RING_LAST) state_d = S_IDLE;
                    else                         ring_cnt_d = ring_cnt_q + 1'b1;
                end
            end
            S_SNOOZE: begin
                if (stop || cancel) begin
                    state_d = S_IDLE;
                end else if (sec_tick) begin
                    if (snz_cnt_q == '0) begin
                        state_d    = S_RING;
                        ring_cnt_d = '0;
                    end else begin
                        snz_cnt_d = snz_cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        alarm_out_d = (state_d == S_RING);
        snoozing_d  = (state_d == S_SNOOZE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: slot storage is reset explicitly; a cleared alarm table after reset is required behaviour.
            for (int i = 0; i < SLOTS; i++) slot_q[i] <= '0;
            state_q     <= S_IDLE;
            ring_cnt_q  <= '0;
            snz_cnt_q   <= '0;
            ring_slot_q <= '0;
            alarm_out_q <= 1'b0;
            snoozing_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < SLOTS; i++) slot_q[i] <= slot_d[i];
            state_q     <= state_d;
            ring_cnt_q  <= ring_cnt_d;
            snz_cnt_q   <= snz_cnt_d;
            ring_slot_q <= ring_slot_d;
            alarm_out_q <= alarm_out_d;
            snoozing_q  <= snoozing_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign alarm_out = alarm_out_q;
    assign ring_slot = ring_slot_q;
    assign snoozing  = snoozing_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Directed self-checking bench for alarm_scheduler with the default 4 slots,
// 60 s ring and 300 s snooze.
module tb_alarm_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       sec_tick;
    logic [7:0] cur_hour, cur_min, cur_sec;
    logic       cfg_we;
    logic [1:0] cfg_slot;
    logic [7:0] cfg_hour, cfg_min, cfg_sec;
    logic       cfg_en;
    logic       stop, snooze;
    logic       alarm_out;
    logic [1:0] ring_slot;
    logic       snoozing;
    logic       cfg_err;

    int checks = 0;
    int errors = 0;

    alarm_scheduler dut (
        .clk(clk), .reset(reset), .sec_tick(sec_tick),
        .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
        .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_hour(cfg_hour),
        .cfg_min(cfg_min), .cfg_sec(cfg_sec), .cfg_en(cfg_en),
        .stop(stop), .snooze(snooze), .alarm_out(alarm_out),
        .ring_slot(ring_slot), .snoozing(snoozing), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one sec_tick cycle; returns on the falling edge after the tick was clocked.
    task automatic tick(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        @(negedge clk);
        sec_tick = 1'b1; cur_hour = h; cur_min = m; cur_sec = s;
        @(negedge clk);
        sec_tick = 1'b0;
    endtask

    task automatic filler(input int n);
        for (int i = 0; i < n; i++) tick(8'd12, 8'd34, 8'd56);
    endtask

    task automatic write(input logic [1:0] sl, input logic [7:0] h, input logic [7:0] m,
                         input logic [7:0] s, input logic en);
        @(negedge clk);
        cfg_we = 1'b1; cfg_slot = sl; cfg_hour = h; cfg_min = m; cfg_sec = s; cfg_en = en;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic pulse(input logic do_stop, input logic do_snooze);
        @(negedge clk);
        stop = do_stop; snooze = do_snooze;
        @(negedge clk);
        stop = 1'b0; snooze = 1'b0;
    endtask

    initial begin
        reset = 1'b1; sec_tick = 1'b0; cur_hour = '0; cur_min = '0; cur_sec = '0;
        cfg_we = 1'b0; cfg_slot = '0; cfg_hour = '0; cfg_min = '0; cfg_sec = '0;
        cfg_en = 1'b0; stop = 1'b0; snooze = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_alarm", alarm_out, 0);
        check("rst_snoozing", snoozing, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_ring_slot", ring_slot, 0);
        reset = 1'b0;

        // Basic ring on slot 1, full 60-tick duration
        write(2'd1, 8'd7, 8'd30, 8'd0, 1'b1);
        check("valid_write_no_err", cfg_err, 0);
        tick(8'd7, 8'd29, 8'd59);
        check("no_ring_before", alarm_out, 0);
        tick(8'd7, 8'd30, 8'd0);
        check("ring_rise", alarm_out, 1);
        check("ring_slot_1", ring_slot, 1);
        filler(59);
        check("ring_after_59", alarm_out, 1);
        filler(1);
        check("ring_fall_60", alarm_out, 0);
        check("ring_slot_held", ring_slot, 1);

        // Simultaneous matches pick the lowest slot; match during ring is dropped
        write(2'd0, 8'd6, 8'd0, 8'd0, 1'b1);
        write(2'd2, 8'd6, 8'd0, 8'd0, 1'b1);
        write(2'd3, 8'd6, 8'd0, 8'd5, 1'b1);
        tick(8'd6, 8'd0, 8'd0);
        check("prio_ring", alarm_out, 1);
        check("prio_slot0", ring_slot, 0);
        for (int s = 1; s <= 5; s++) tick(8'd6, 8'd0, 8'(s));
        check("drop_match_slot", ring_slot, 0);
        check("drop_match_ring", alarm_out, 1);
        pulse(1'b1, 1'b0);
        check("stop_alarm", alarm_out, 0);
        check("stop_snoozing", snoozing, 0);

        // Snooze at tick 10, re-ring after exactly 300 ticks (extra snooze ignored)
        tick(8'd6, 8'd0, 8'd0);
        check("snz_ring", alarm_out, 1);
        filler(9);
        pulse(1'b0, 1'b1);
        check("snz_enter", snoozing, 1);
        check("snz_alarm_off", alarm_out, 0);
        filler(100);
        pulse(1'b0, 1'b1);
        check("snz_ignored", snoozing, 1);
        filler(199);
        check("snz_299_still", snoozing, 1);
        check("snz_299_alarm", alarm_out, 0);
        filler(1);
        check("rering_alarm", alarm_out, 1);
        check("rering_snoozing", snoozing, 0);
        check("rering_slot", ring_slot, 0);
        pulse(1'b1, 1'b0);
        check("rering_stop", alarm_out, 0);

        // Rejected writes leave the slot intact
        write(2'd1, 8'd24, 8'd0, 8'd0, 1'b0);
        check("err_hour", cfg_err, 1);
        @(negedge clk);
        check("err_one_cycle", cfg_err, 0);
        write(2'd1, 8'd7, 8'd60, 8'd0, 1'b0);
        check("err_min", cfg_err, 1);
        write(2'd1, 8'd7, 8'd30, 8'd60, 1'b0);
        check("err_sec", cfg_err, 1);
        tick(8'd7, 8'd30, 8'd0);
        check("old_time_rings", alarm_out, 1);
        check("old_time_slot", ring_slot, 1);

        // stop wins over snooze
        pulse(1'b1, 1'b1);
        check("stop_snz_alarm", alarm_out, 0);
        check("stop_snz_snoozing", snoozing, 0);
        @(negedge clk);
        check("stop_snz_stays", snoozing, 0);

        // Cancel via disabling write during snooze; unrelated slot write does nothing
        tick(8'd6, 8'd0, 8'd0);
        check("cancel_ring_slot", ring_slot, 0);
        pulse(1'b0, 1'b1);
        write(2'd2, 8'd6, 8'd0, 8'd0, 1'b0);
        check("other_write_keep", snoozing, 1);
        write(2'd0, 8'd6, 8'd0, 8'd0, 1'b0);
        check("cancel_snoozing", snoozing, 0);
        check("cancel_alarm", alarm_out, 0);
        tick(8'd6, 8'd0, 8'd0);
        check("disabled_no_ring", alarm_out, 0);

        // Same-cycle tick and write: match uses pre-write contents
        @(negedge clk);
        sec_tick = 1'b1; cur_hour = 8'd6; cur_min = 8'd0; cur_sec = 8'd5;
        cfg_we = 1'b1; cfg_slot = 2'd3; cfg_hour = 8'd6; cfg_min = 8'd0; cfg_sec = 8'd6; cfg_en = 1'b1;
        @(negedge clk);
        sec_tick = 1'b0; cfg_we = 1'b0;
        check("same_cycle_ring", alarm_out, 1);
        check("same_cycle_slot", ring_slot, 3);

        // Async reset mid-ring clears outputs and slots
        #2 reset = 1'b1;
        #1;
        check("async_rst_alarm", alarm_out, 0);
        check("async_rst_slot", ring_slot, 0);
        @(negedge clk);
        reset = 1'b0;
        tick(8'd7, 8'd30, 8'd0);
        check("cleared_slot1", alarm_out, 0);
        tick(8'd6, 8'd0, 8'd6);
        check("cleared_slot3", alarm_out, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alarm_scheduler.md
# alarm_scheduler

Multi-slot alarm controller for the clock: holds SLOTS programmable alarm times, compares them once per second against the running time, and sequences the ring, snooze and dismiss behaviour. It sits between the timekeeping counter (current hour/min/sec plus a one-second tick) and the buzzer/user-button logic, and owns all alarm configuration.

## Interface
- SLOTS, 4: number of alarm slots; slot index width is clog2(SLOTS), minimum 1.
- RING_SECS, 60: ring duration in seconds before auto-dismiss; must be ≥1.
- SNOOZE_SECS, 300: snooze delay in seconds; must be ≥1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high; clock clk.
- sec_tick  in  1  one-cycle pulse, once per second; cur_* are valid on this cycle.
- cur_hour / cur_min / cur_sec  in  8 each  current time, binary (0–23 / 0–59 / 0–59).
- cfg_we  in  1  one-cycle slot write strobe.
- cfg_slot  in  clog2(SLOTS)  slot being written.
- cfg_hour / cfg_min / cfg_sec  in  8 each  alarm time to store.
- cfg_en  in  1  enable bit to store.
- stop  in  1  dismiss, level sampled per cycle.
- snooze  in  1  snooze request, level sampled per cycle.
- alarm_out  out  1  buzzer drive, high in RING.
- ring_slot  out  clog2(SLOTS)  slot that triggered the current ring/snooze.
- snoozing  out  1  high in SNOOZE.
- cfg_err  out  1  one-cycle pulse: last write rejected.

## Operation
- Slot storage: per slot hour, min, sec (8 b) and en. Reset: all zero, en=0.
- Write: on cfg_we, if cfg_hour≤23, cfg_min≤59, cfg_sec≤59 and cfg_slot<SLOTS, slot is overwritten (all four fields); otherwise slot unchanged and cfg_err pulses.
- Match: slot i matches when en_i=1 and hour/min/sec equal cur_* exactly; evaluated only on sec_tick cycles. Multiple matches: lowest index wins.
- FSM states IDLE, RING, SNOOZE. Reset → IDLE.
- IDLE: sec_tick with a match → RING; ring_slot ← winner; ring_cnt ← 0.
- RING: alarm_out=1. Priority per cycle: stop → IDLE; else snooze → SNOOZE, snz_cnt ← SNOOZE_SECS−1; else on sec_tick: if ring_cnt==RING_SECS−1 → IDLE, else ring_cnt+1.
- SNOOZE: snoozing=1, alarm_out=0. stop → IDLE; snooze ignored; on sec_tick: if snz_cnt==0 → RING with ring_cnt ← 0, ring_slot kept; else snz_cnt−1.
- Matches occurring in RING or SNOOZE are dropped (not queued).
- Write with cfg_en=0 to the slot equal to ring_slot while in RING or SNOOZE → IDLE next cycle (cancel). Other writes do not affect the FSM.
- sec_tick and cfg_we in the same cycle: match uses pre-write slot contents.
- Counter widths: ring_cnt clog2(RING_SECS+1), snz_cnt clog2(SNOOZE_SECS+1); no wrap possible by construction.
- ring_slot holds its value in IDLE (last triggering slot; 0 after reset).

## Timing
- All outputs registered. Reset values: alarm_out=0, snoozing=0, cfg_err=0, ring_slot=0.
- alarm_out rises the cycle after the matching sec_tick; stays high for exactly RING_SECS sec_tick pulses (counting the first tick after entry), falling the cycle after the last one.
- stop/snooze: state and outputs change the cycle after assertion.
- Snooze re-ring: alarm_out rises the cycle after the SNOOZE_SECS-th sec_tick following snooze entry.
- Slot write visible to a match on the next sec_tick after the cfg_we cycle. cfg_err pulses the cycle after cfg_we, one cycle wide.
- Reset mid-ring or mid-snooze: all outputs and slots return to reset values immediately (async).

## Test plan
- Write slot 1 = 07:30:00 en=1; drive time 07:29:59 → 07:30:00 ticks → alarm_out rises cycle after 07:30:00 tick, ring_slot=1, falls after 60th tick.
- Slots 0 and 2 both 06:00:00 enabled → ring_slot=0; during ring, slot 3 matching 06:00:05 is ignored.
- Ring, assert snooze at tick 10 → snoozing=1, alarm_out=0; 300 ticks later alarm_out=1 again, ring_slot unchanged; stop → IDLE.
- Write cfg_hour=24 (and cfg_min=60) → cfg_err pulses, slot readback via later match unaffected (old time still triggers).
- stop and snooze asserted together in RING → IDLE, snoozing stays 0; write slot=ring_slot with en=0 during SNOOZE → IDLE.
- Assert reset mid-ring → alarm_out=0 immediately; after release, previously programmed time no longer triggers (slots cleared).
